ram_stream_reader: RTL and testbench

//  Reader front-end for the dual-port block RAM read port: on a start command it

---
 rtl/ram_stream_reader.sv | 208 ++++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Reader front-end for a block-RAM read port. A start command captures a
//   base address and a word count. The block then walks that address window,
//   wrapping modulo 2**ADDR_WIDTH, and absorbs the RAM's 1-cycle registered
//   read latency. It streams the words out on a valid/ready interface with
//   full backpressure.
//
// Build option:
//   STREAM_LAST_EN  adds output m_last, which marks the final word of a burst.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      1-cycle command pulse, only sampled while idle
//   base_addr  first address read, captured on start
//   length     word count 0..2**ADDR_WIDTH, captured on start
//   rdaddress  RAM read address
//   ram_q      RAM read data, valid 1 cycle after rdaddress is issued
//   m_data     stream data
//   m_valid    stream valid
//   m_ready    stream ready from the consumer
//   m_last     (STREAM_LAST_EN only) final word of the burst, qualified by m_valid
//   busy       high from the cycle after an accepted start until done
//   done       1-cycle pulse in the cycle after the last word is accepted
module ram_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef STREAM_LAST_EN
  output logic                  m_last,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] OneCnt = 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     issue_rem_q, issue_rem_d;
  logic [ADDR_WIDTH:0]     xfer_rem_q, xfer_rem_d;
  logic [ADDR_WIDTH-1:0]   rdaddress_q, rdaddress_d;
  logic                    inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]   buf_data_q [2];
  logic [DATA_WIDTH-1:0]   buf_data_d [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef STREAM_LAST_EN
  logic                    inflight_last_q, inflight_last_d;
  logic                    buf_last_q [2];
  logic                    buf_last_d [2];
`endif

  logic buf_empty, room, issue, xfer, bypass, push, pop;

  // Datapath decode. When the buffer is empty, the in-flight word is
  // forwarded straight from ram_q. This meets the start+2 first-word latency.
  // A stalled bypass word is pushed into the buffer in the same cycle, so
  // m_data does not change while the consumer stalls.
  always_comb begin
    buf_empty = (count_q == 2'd0);
    // Occupancy plus in-flight must stay below 2, so a word always has a slot.
    room      = (count_q == 2'd0) || ((count_q == 2'd1) && !inflight_q);
    issue     = (state_q == StRead) && (issue_rem_q != '0) && room;
    m_valid   = !buf_empty || inflight_q;
    m_data    = !buf_empty ? buf_data_q[rd_ptr_q] : (inflight_q ? ram_q : '0);
`ifdef STREAM_LAST_EN
    m_last    = !buf_empty ? buf_last_q[rd_ptr_q] : (inflight_q && inflight_last_q);
`endif
    xfer      = m_valid && m_ready;
    bypass    = buf_empty && inflight_q && m_ready;
    push      = inflight_q && !bypass;
    pop       = !buf_empty && m_ready;
    // Hold the last issued address when no read is issued.
    rdaddress = issue ? addr_q : rdaddress_q;
  end

  // Next-state logic for the control FSM and the counters.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_rem_d = issue_rem_q;
    xfer_rem_d  = xfer_rem_q;
    rdaddress_d = rdaddress;
    inflight_d  = issue;
    done_d      = 1'b0;
`ifdef STREAM_LAST_EN
    inflight_last_d = issue ? (issue_rem_q == OneCnt) : 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = StRead;
            addr_d      = base_addr;
            issue_rem_d = length;
            xfer_rem_d  = length;
          end
        end
      end
      StRead: begin
        if (issue) begin
          addr_d      = addr_q + 1'b1;
          issue_rem_d = issue_rem_q - OneCnt;
          if (issue_rem_q == OneCnt) state_d = StDrain;
        end
      end
      StDrain: ;
      default: state_d = StIdle;
    endcase

    if ((state_q != StIdle) && xfer) begin
      xfer_rem_d = xfer_rem_q - OneCnt;
      if (xfer_rem_q == OneCnt) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end

    busy_d = (state_d != StIdle);
  end

  // Output buffer: a 2-entry FIFO with independent push and pop.
  always_comb begin
    buf_data_d = buf_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
`ifdef STREAM_LAST_EN
    buf_last_d = buf_last_q;
`endif
    if (push) begin
      buf_data_d[wr_ptr_q] = ram_q;
`ifdef STREAM_LAST_EN
      buf_last_d[wr_ptr_q] = inflight_last_q;
`endif
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      issue_rem_q   <= '0;
      xfer_rem_q    <= '0;
      rdaddress_q   <= '0;
      inflight_q    <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef STREAM_LAST_EN
      inflight_last_q <= 1'b0;
      buf_last_q[0]   <= 1'b0;
      buf_last_q[1]   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_rem_q <= issue_rem_d;
      xfer_rem_q  <= xfer_rem_d;
      rdaddress_q <= rdaddress_d;
      inflight_q  <= inflight_d;
      buf_data_q  <= buf_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef STREAM_LAST_EN
      inflight_last_q <= inflight_last_d;
      buf_last_q      <= buf_last_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader. A behavioural RAM with a 1-cycle
// registered read feeds the DUT. The expected stream for every burst is
// computed from the RAM contents, the base address and the length.
module tb_ram_stream_reader;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;
`ifdef STREAM_LAST_EN
  logic          m_last;
`endif

  logic [DW-1:0] mem [Depth];
  int total = 0;
  int bad = 0;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .rdaddress (rdaddress),
    .ram_q     (ram_q),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
`ifdef STREAM_LAST_EN
    .m_last    (m_last),
`endif
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[rdaddress];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for cycles 3..12.
  // poke issues a second start mid-burst, which must be ignored.
  // abort_at >= 0 returns early once that many words have been accepted.
  task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] len, input int mode,
                           input bit poke, input int abort_at);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev_data;
    int  got = 0;
    int  cyc = 1;
    int  done_cnt = 0;
    int  last_cyc = -10;
    int  budget;
    bit  prev_stall = 0;
    bit  finished = 0;
    bit  exp_done;
    for (int i = 0; i < int'(len); i++) exp_q.push_back(mem[(int'(base) + i) % Depth]);
    budget = int'(len) * 8 + 20;
    @(negedge clk);
    start = 1'b1; base_addr = base; length = len;
    @(negedge clk);
    start = 1'b0;
    while (!finished && cyc <= budget) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (cyc >= 3 && cyc < 13) ? 1'b0 : 1'($urandom_range(0, 1));
      endcase
      if (poke) begin
        start = (cyc == 3); base_addr = 8'h80; length = 9'd5;
      end
      #1;
      if (cyc == 1 && len != 0) check("first_rdaddr", 32'(rdaddress), 32'(base));
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_data));
      end
      check("busy", 32'(busy), 32'(len != 0 && got < int'(len)));
      exp_done = (len == 0) ? (cyc == 1) : (got == int'(len) && cyc == last_cyc + 1);
      check("done", 32'(done), 32'(exp_done));
      if (len == 0) check("zero_valid", 32'(m_valid), 32'd0);
      if (done) done_cnt++;
      if (m_valid && m_ready) begin
        if (got < int'(len)) begin
          check("data", 32'(m_data), 32'(exp_q[got]));
          if (mode == 0) check("timing", cyc, got + 2);
`ifdef STREAM_LAST_EN
          check("m_last", 32'(m_last), 32'(got == int'(len) - 1));
`endif
        end else begin
          check("extra_xfer", got + 1, int'(len));
        end
        got++;
        last_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (abort_at >= 0 && got == abort_at) return;
      if ((len != 0 && done) || (len == 0 && cyc >= 3)) finished = 1'b1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("xfer_count", got, int'(len));
    check("done_count", done_cnt, 1);
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) mem[i] = DW'(i);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_rdaddr", 32'(rdaddress), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    run_burst(8'h10, 9'd4, 0, 1'b0, -1);   // basic stream, exact timing
    run_burst(8'hFE, 9'd4, 0, 1'b0, -1);   // address wrap
    run_burst(8'h20, 9'd8, 2, 1'b0, -1);   // long stall then random ready
    run_burst(8'h30, 9'd0, 0, 1'b0, -1);   // zero length
    run_burst(8'h00, 9'd256, 0, 1'b0, -1); // full window
    run_burst(8'h40, 9'd8, 1, 1'b1, -1);   // start while busy ignored

    // Reset in the middle of a burst.
    run_burst(8'h00, 9'd8, 0, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_data", 32'(m_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rdaddr", 32'(rdaddress), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_done", 32'(done), 32'd0);
      check("postrst_valid", 32'(m_valid), 32'd0);
    end
    run_burst(8'h00, 9'd2, 0, 1'b0, -1);

    // Random contents, windows and backpressure.
    for (int i = 0; i < Depth; i++) mem[i] = DW'($urandom);
    for (int n = 0; n < 6; n++)
      run_burst(AW'($urandom), 9'($urandom_range(1, 20)), 1, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
